// File: rtl/fifo_asym_rtl.sv
// fifo_asym_rtl: single-clock FIFO whose write and read words differ in width
// by a power-of-two ratio.
//
// Storage is WR_DATA_WIDTH wide and WR_DATA_DEPTH entries deep. All flags come
// from one fill counter that counts in units of min(WR, RD) bits.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   wr_en, wr_data         write request / write word
//   full, prog_full        no room for a write word / wr_count >= threshold
//   wr_count               stored data in whole write words
//   wr_err                 one-cycle pulse for a write attempted while full
//   rd_en                  read request
//   rd_data, rd_valid      registered read word / strobe for a fresh word
//   empty                  less than one read word stored
//   rd_count               stored data in whole read words
//   rd_err                 one-cycle pulse for a read attempted while empty

// One storage bank with a registered, resettable read port.
module fifo_asym_lane #(
  parameter int W  = 32,
  parameter int D  = 2,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module fifo_asym_rtl #(
  parameter int WR_DATA_WIDTH    = 32,
  parameter int RD_DATA_WIDTH    = 256,
  parameter int WR_DATA_DEPTH    = 256,
  parameter int PROG_FULL_THRESH = 192
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [WR_DATA_WIDTH-1:0]          wr_data,
  output logic                              full,
  output logic                              prog_full,
  output logic [$clog2(WR_DATA_DEPTH):0]    wr_count,
  output logic                              wr_err,
  input  logic                              rd_en,
  output logic [RD_DATA_WIDTH-1:0]          rd_data,
  output logic                              rd_valid,
  output logic                              empty,
  output logic [$clog2(WR_DATA_DEPTH*((WR_DATA_WIDTH > RD_DATA_WIDTH) ?
                (WR_DATA_WIDTH/RD_DATA_WIDTH) : 1)):0] rd_count,
  output logic                              rd_err
);
  localparam int UNIT = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
  localparam int WU   = WR_DATA_WIDTH / UNIT;   // units per write word
  localparam int RU   = RD_DATA_WIDTH / UNIT;   // units per read word
  localparam int N    = WR_DATA_DEPTH * WU;     // capacity in units
  localparam int FW   = $clog2(N) + 1;
  localparam int LWU  = $clog2(WU);
  localparam int LRU  = $clog2(RU);
  localparam int WPW  = $clog2(WR_DATA_DEPTH);
  localparam int WCW  = $bits(wr_count);
  localparam int RCW  = $bits(rd_count);

  localparam logic [FW-1:0] FULL_LIM = FW'(N - WU);
  localparam logic [FW-1:0] WU_F     = FW'(WU);
  localparam logic [FW-1:0] RU_F     = FW'(RU);
  localparam logic [FW-1:0] PF_LIM   = FW'(PROG_FULL_THRESH);

  logic [FW-1:0]  fill_q, fill_d;
  logic [WPW-1:0] wptr_q;
  logic           full_q, empty_q, pfull_q;
  logic           wr_err_q, rd_err_q, rd_valid_q;
  logic           wr_acc, rd_acc;

  // Acceptance uses pre-edge flags: a read in the same cycle never frees
  // room for a write that arrives while full.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    fill_d = fill_q;
    if (wr_acc) fill_d = fill_d + WU_F;
    if (rd_acc) fill_d = fill_d - RU_F;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= '0;
      wptr_q     <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      pfull_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      full_q     <= fill_d > FULL_LIM;
      empty_q    <= fill_d < RU_F;
      pfull_q    <= (fill_d >> LWU) >= PF_LIM;
      wr_err_q   <= wr_en & full_q;
      rd_err_q   <= rd_en & empty_q;
      rd_valid_q <= rd_acc;
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign prog_full = pfull_q;
  assign wr_err    = wr_err_q;
  assign rd_err    = rd_err_q;
  assign rd_valid  = rd_valid_q;
  assign wr_count  = WCW'(fill_q >> LWU);
  assign rd_count  = RCW'(fill_q >> LRU);

  if (RD_DATA_WIDTH > WR_DATA_WIDTH) begin : g_up
    // Entries are striped across RU banks (entry i -> bank i%RU, row i/RU).
    // Reads always start on an RU-aligned entry, so one row read across all
    // banks yields a whole read word, oldest entry in the lowest lane.
    localparam int BD = WR_DATA_DEPTH / RU;
    localparam int RW = $clog2(BD);

    logic [RW-1:0]  rrow_q;
    logic [LRU-1:0] wsel;
    logic [RW-1:0]  wrow;

    assign wsel = wptr_q[LRU-1:0];
    assign wrow = wptr_q[WPW-1:LRU];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rrow_q <= '0;
      else if (rd_acc) rrow_q <= rrow_q + 1'b1;
    end

    for (genvar b = 0; b < RU; b++) begin : g_lane
      fifo_asym_lane #(.W(WR_DATA_WIDTH), .D(BD), .AW(RW)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_acc && (wsel == LRU'(b))),
        .waddr_i (wrow),
        .wdata_i (wr_data),
        .re_i    (rd_acc),
        .raddr_i (rrow_q),
        .rdata_o (rd_data[b*WR_DATA_WIDTH +: WR_DATA_WIDTH])
      );
    end
  end else begin : g_dn
    // Read pointer counts read words: upper bits pick the entry, low LWU
    // bits pick the slice (LSB slice first).
    localparam int RPW = WPW + LWU;

    logic [RPW-1:0]           rptr_q;
    logic [WR_DATA_WIDTH-1:0] ent;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rptr_q <= '0;
      else if (rd_acc) rptr_q <= rptr_q + 1'b1;
    end

    fifo_asym_lane #(.W(WR_DATA_WIDTH), .D(WR_DATA_DEPTH), .AW(WPW)) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_acc),
      .waddr_i (wptr_q),
      .wdata_i (wr_data),
      .re_i    (rd_acc),
      .raddr_i (rptr_q[RPW-1:LWU]),
      .rdata_o (ent)
    );

    if (WU > 1) begin : g_sl
      // Slice select travels with the registered entry so rd_data holds
      // steady between reads.
      logic [LWU-1:0] sl_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sl_q <= '0;
        else if (rd_acc) sl_q <= rptr_q[LWU-1:0];
      end
      assign rd_data = ent[sl_q*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end else begin : g_eq
      assign rd_data = ent;
    end
  end
endmodule

// File: tb/tb_fifo_asym_rtl.sv
// Bench for fifo_asym_rtl: one upsizing instance (defaults, 32->256) and one
// downsizing instance (256->32, depth 16). Both are modelled as a queue of
// 32-bit units; flag expectations follow from the queue length.
module tb_fifo_asym_rtl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // upsizing DUT
  logic         up_rst_n = 1'b0, up_wr_en = 1'b0, up_rd_en = 1'b0;
  logic [31:0]  up_wr_data = '0;
  logic         up_full, up_pfull, up_wr_err, up_rd_valid, up_empty, up_rd_err;
  logic [8:0]   up_wr_count, up_rd_count;
  logic [255:0] up_rd_data;

  // downsizing DUT
  logic         dn_rst_n = 1'b0, dn_wr_en = 1'b0, dn_rd_en = 1'b0;
  logic [255:0] dn_wr_data = '0;
  logic         dn_full, dn_pfull, dn_wr_err, dn_rd_valid, dn_empty, dn_rd_err;
  logic [4:0]   dn_wr_count;
  logic [7:0]   dn_rd_count;
  logic [31:0]  dn_rd_data;

  fifo_asym_rtl u_up (
    .clk(clk), .rst_n(up_rst_n), .wr_en(up_wr_en), .wr_data(up_wr_data),
    .full(up_full), .prog_full(up_pfull), .wr_count(up_wr_count), .wr_err(up_wr_err),
    .rd_en(up_rd_en), .rd_data(up_rd_data), .rd_valid(up_rd_valid), .empty(up_empty),
    .rd_count(up_rd_count), .rd_err(up_rd_err)
  );

  fifo_asym_rtl #(.WR_DATA_WIDTH(256), .RD_DATA_WIDTH(32), .WR_DATA_DEPTH(16),
                  .PROG_FULL_THRESH(12)) u_dn (
    .clk(clk), .rst_n(dn_rst_n), .wr_en(dn_wr_en), .wr_data(dn_wr_data),
    .full(dn_full), .prog_full(dn_pfull), .wr_count(dn_wr_count), .wr_err(dn_wr_err),
    .rd_en(dn_rd_en), .rd_data(dn_rd_data), .rd_valid(dn_rd_valid), .empty(dn_empty),
    .rd_count(dn_rd_count), .rd_err(dn_rd_err)
  );

  // reference state
  logic [31:0]  uq[$];
  logic [255:0] up_last = '0;
  bit           up_ev, up_ewe, up_ere;
  logic [31:0]  dq[$];
  logic [31:0]  dn_last = '0;
  bit           dn_ev, dn_ewe, dn_ere;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // up: N=256 units, WU=1, RU=8, threshold 192
  task automatic chk_up();
    int s;
    s = uq.size();
    chk("up_rd_valid",  256'(up_rd_valid), 256'(up_ev));
    chk("up_rd_data",   up_rd_data, up_last);
    chk("up_wr_err",    256'(up_wr_err), 256'(up_ewe));
    chk("up_rd_err",    256'(up_rd_err), 256'(up_ere));
    chk("up_full",      256'(up_full), 256'(s > 255));
    chk("up_empty",     256'(up_empty), 256'(s < 8));
    chk("up_prog_full", 256'(up_pfull), 256'(s >= 192));
    chk("up_wr_count",  256'(up_wr_count), 256'(s));
    chk("up_rd_count",  256'(up_rd_count), 256'(s / 8));
  endtask

  // dn: N=128 units, WU=8, RU=1, threshold 12 write words
  task automatic chk_dn();
    int s;
    s = dq.size();
    chk("dn_rd_valid",  256'(dn_rd_valid), 256'(dn_ev));
    chk("dn_rd_data",   256'(dn_rd_data), 256'(dn_last));
    chk("dn_wr_err",    256'(dn_wr_err), 256'(dn_ewe));
    chk("dn_rd_err",    256'(dn_rd_err), 256'(dn_ere));
    chk("dn_full",      256'(dn_full), 256'(s > 120));
    chk("dn_empty",     256'(dn_empty), 256'(s < 1));
    chk("dn_prog_full", 256'(dn_pfull), 256'(s / 8 >= 12));
    chk("dn_wr_count",  256'(dn_wr_count), 256'(s / 8));
    chk("dn_rd_count",  256'(dn_rd_count), 256'(s));
  endtask

  task automatic step_up(input bit we, input logic [31:0] wd, input bit re);
    bit wa, ra;
    wa = we && !(uq.size() > 255);
    ra = re && !(uq.size() < 8);
    up_wr_en = we; up_wr_data = wd; up_rd_en = re;
    @(posedge clk); #1;
    up_ev = ra; up_ewe = we && !wa; up_ere = re && !ra;
    if (ra) for (int i = 0; i < 8; i++) up_last[i*32 +: 32] = uq.pop_front();
    if (wa) uq.push_back(wd);
    up_wr_en = 1'b0; up_rd_en = 1'b0;
    chk_up();
  endtask

  task automatic step_dn(input bit we, input logic [255:0] wd, input bit re);
    bit wa, ra;
    wa = we && !(dq.size() > 120);
    ra = re && (dq.size() >= 1);
    dn_wr_en = we; dn_wr_data = wd; dn_rd_en = re;
    @(posedge clk); #1;
    dn_ev = ra; dn_ewe = we && !wa; dn_ere = re && !ra;
    if (ra) dn_last = dq.pop_front();
    if (wa) for (int i = 0; i < 8; i++) dq.push_back(wd[i*32 +: 32]);
    dn_wr_en = 1'b0; dn_rd_en = 1'b0;
    chk_dn();
  endtask

  // Async reset asserted mid-cycle; outputs must drop before any edge.
  task automatic reset_up();
    @(negedge clk); #2;
    up_rst_n = 1'b0; up_wr_en = 1'b0; up_rd_en = 1'b0;
    #1;
    uq.delete(); up_last = '0; up_ev = 0; up_ewe = 0; up_ere = 0;
    chk_up();
    @(negedge clk);
    up_rst_n = 1'b1;
  endtask

  task automatic reset_dn();
    @(negedge clk); #2;
    dn_rst_n = 1'b0; dn_wr_en = 1'b0; dn_rd_en = 1'b0;
    #1;
    dq.delete(); dn_last = '0; dn_ev = 0; dn_ewe = 0; dn_ere = 0;
    chk_dn();
    @(negedge clk);
    dn_rst_n = 1'b1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] w;
    int words;
    bit did_rst;

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    up_ev = 0; up_ewe = 0; up_ere = 0; dn_ev = 0; dn_ewe = 0; dn_ere = 0;
    chk_up();
    chk_dn();
    @(negedge clk);
    up_rst_n = 1'b1; dn_rst_n = 1'b1;

    // upsize directed: 8 words then one wide read
    for (int i = 0; i < 8; i++) step_up(1'b1, 32'(i), 1'b0);
    chk("up_empty_after8", 256'(up_empty), 256'(0));
    step_up(1'b0, '0, 1'b1);
    chk("up_dir_data", up_rd_data,
        256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    step_up(1'b0, '0, 1'b0);
    chk("up_dir_empty", 256'(up_empty), 256'(1));

    // underflow: rd_err, no valid, data held
    step_up(1'b0, '0, 1'b1);
    chk("up_underflow", 256'(up_rd_err), 256'(1));

    // fill to full, overflow, drain
    for (int i = 0; i < 256; i++) step_up(1'b1, 32'($urandom), 1'b0);
    chk("up_full_256", 256'(up_full), 256'(1));
    step_up(1'b1, 32'hdeadbeef, 1'b0);
    chk("up_ovf_err", 256'(up_wr_err), 256'(1));
    chk("up_ovf_count", 256'(up_wr_count), 256'(256));
    for (int i = 0; i < 32; i++) step_up(1'b0, '0, 1'b1);

    // simultaneous write+read at fill 16
    for (int i = 0; i < 16; i++) step_up(1'b1, 32'($urandom), 1'b0);
    step_up(1'b1, 32'($urandom), 1'b1);
    chk("up_simul_wr_count", 256'(up_wr_count), 256'(9));
    chk("up_simul_rd_count", 256'(up_rd_count), 256'(1));

    // upsize random stream with mid-stream reset
    words = 0; did_rst = 0;
    for (int c = 0; c < 6000 && words < 1000; c++) begin
      bit we, re;
      int rp;
      rp = ((c / 300) % 2 == 0) ? 2 : 20;
      we = $urandom_range(0, 99) < 60;
      re = $urandom_range(0, 99) < rp;
      if (we && uq.size() <= 255) words++;
      step_up(we, 32'($urandom), re);
      if (!did_rst && words >= 500) begin
        reset_up();
        did_rst = 1;
      end
    end
    chk("up_stream_words", 256'(words >= 1000), 256'(1));

    // downsize directed: lanes k = k
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(k);
    step_dn(1'b1, w, 1'b0);
    chk("dn_rd_count8", 256'(dn_rd_count), 256'(8));
    for (int k = 0; k < 8; k++) begin
      step_dn(1'b0, '0, 1'b1);
      chk("dn_dir_data", 256'(dn_rd_data), 256'(k));
    end
    chk("dn_dir_empty", 256'(dn_empty), 256'(1));
    chk("dn_dir_rd_count", 256'(dn_rd_count), 256'(0));
    step_dn(1'b0, '0, 1'b1);
    chk("dn_underflow", 256'(dn_rd_err), 256'(1));

    // downsize random stream with mid-stream reset
    words = 0; did_rst = 0;
    for (int c = 0; c < 6000 && words < 1000; c++) begin
      bit we, re;
      int rp;
      rp = ((c / 300) % 2 == 0) ? 50 : 90;
      we = $urandom_range(0, 99) < 15;
      re = $urandom_range(0, 99) < rp;
      if (we && dq.size() <= 120) words += 8;
      step_dn(we, rnd256(), re);
      if (!did_rst && words >= 500) begin
        reset_dn();
        did_rst = 1;
      end
    end
    chk("dn_stream_words", 256'(words >= 1000), 256'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
